demux_dispatch_ctrl: RTL

Sequencing controller for the demultiplexer datapath. Accepts one data word at a time on a valid/ready input and steers it to one of N_OUT output channels, held on a shared output data bus. The target is either addressed explicitly or picked round-robin among enabled outputs. A stalled delivery is abandoned after a programmable timeout and counted as a drop. It sits between a single producer and N_OUT consumers in place of a bare 1-to-N demux.

---
 rtl/demux_ctrl_pkg.sv | 9 +
 rtl/rr_pick.sv | 28 ++
 rtl/demux_dispatch_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the demux dispatch controller.
package demux_ctrl_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: lowest set mask bit at or above base, with wrap.
module rr_pick #(
  parameter int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic [N_OUT-1:0] mask,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] j;

  // Scan from farthest to nearest so the nearest hit wins; index wraps naturally.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      j = base + SEL_W'(i);
      if (mask[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-producer to N_OUT-consumer dispatch controller with addressed or
// round-robin steering, stall timeout and a saturating drop counter.
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_OUT   = 4,
  parameter int TIMEOUT = 16,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic              rr_mode,
  input  logic [N_OUT-1:0]  out_en,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              drop_pulse,
  output logic [DROP_W-1:0] drop_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_OUT-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] hold_data;
  logic [SEL_W-1:0]  target;
  logic              held_rr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SEL_W-1:0]  rr_ptr;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [SEL_W-1:0]  cap_tgt;
  logic              cap_drop;
  logic              timed_out;

  rr_pick #(.N_OUT(N_OUT)) u_pick (
    .mask (out_en),
    .base (rr_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign in_ready  = !rst && (state == IDLE) && (!rr_mode || (|out_en));
  assign cap_tgt   = rr_mode ? pick_idx : in_dest;
  assign cap_drop  = rr_mode ? !pick_any : !out_en[in_dest];
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign out_data  = hold_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_data  <= '0;
      target     <= '0;
      held_rr    <= 1'b0;
      wait_cnt   <= '0;
      rr_ptr     <= '0;
      out_valid  <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            hold_data <= in_data;
            wait_cnt  <= '0;
            target    <= cap_tgt;
            held_rr   <= rr_mode;
            if (cap_drop) begin
              drop_pulse <= 1'b1;
              drop_count <= sat_inc(drop_count);
            end else begin
              state     <= HOLD;
              out_valid <= onehot(cap_tgt);
            end
          end
        end
        HOLD: begin
          // Target and mode were latched at capture; live out_en/rr_mode are ignored here.
          if (out_ready[target]) begin
            state     <= IDLE;
            out_valid <= '0;
            if (held_rr) rr_ptr <= target + SEL_W'(1);
          end else if (timed_out) begin
            state      <= IDLE;
            out_valid  <= '0;
            drop_pulse <= 1'b1;
            drop_count <= sat_inc(drop_count);
            if (held_rr) rr_ptr <= target + SEL_W'(1);
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
